// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the instruction decode stage.
// Holds ALU opcode encodings, RISC-V opcode/funct constants and the
// decode helper used by id_stage.
package id_stage_pkg;

  // ALU opcodes presented to the execute stage
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_ADDI = 4'd5;

  // Major opcodes
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  // funct3 / funct7 fields
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef struct packed {
    logic       illegal;
    logic       is_imm;   // operand B comes from the immediate
    logic [3:0] alu_op;
  } dec_t;

  // Decode the supported R/I-type subset; anything else is illegal with ALU_ADD.
  function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7);
    dec_t d;
    d.illegal = 1'b1;
    d.is_imm  = 1'b0;
    d.alu_op  = ALU_ADD;
    if (opc == OP_R) begin
      case (f3)
        F3_ADD_SUB: begin
          if (f7 == F7_BASE) begin
            d.illegal = 1'b0;
            d.alu_op  = ALU_ADD;
          end else if (f7 == F7_SUB) begin
            d.illegal = 1'b0;
            d.alu_op  = ALU_SUB;
          end
        end
        F3_AND: if (f7 == F7_BASE) begin
          d.illegal = 1'b0;
          d.alu_op  = ALU_AND;
        end
        F3_OR: if (f7 == F7_BASE) begin
          d.illegal = 1'b0;
          d.alu_op  = ALU_OR;
        end
        F3_XOR: if (f7 == F7_BASE) begin
          d.illegal = 1'b0;
          d.alu_op  = ALU_XOR;
        end
        default: ;
      endcase
    end else if (opc == OP_I && f3 == F3_ADD_SUB) begin
      d.illegal = 1'b0;
      d.is_imm  = 1'b1;
      d.alu_op  = ALU_ADDI;
    end
    return d;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Integer register file: 2 asynchronous read ports, 1 synchronous write port.
// x0 is hardwired to zero; writes to index 0 are dropped.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i  write port (takes effect at the clock edge)
//   raddr_a_i/rdata_a_o   read port A
//   raddr_b_i/rdata_b_o   read port B
module id_stage_regfile #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RA_W     = 5,
  parameter bit          RF_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [RA_W-1:0] waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [RA_W-1:0] raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [RA_W-1:0] raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o
);

  localparam int unsigned NumRegs = 2 ** RA_W;

  logic [XLEN-1:0] mem_q [NumRegs];

  // Reset blocks write-back in the same cycle even when entries are not cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (RF_RESET) begin
        for (int i = 0; i < NumRegs; i++) begin
          mem_q[i] <= '0;
        end
      end
    end else if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage feeding the ALU.
// Accepts an instruction over valid/ready, decodes the R/I-type subset, reads
// operands (with write-back bypass) and registers them into the ID/EX register.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_valid_i/if_instr_i/if_ready_o  fetch handshake
//   flush_i                       kill decode contents and any incoming instruction
//   wb_we_i/wb_rd_i/wb_data_i     register file write port from write-back
//   id_valid_o/id_ready_i         execute handshake
//   id_rs1_val_o/id_rs2_val_o     ALU operands (rs2 or sign-extended immediate)
//   id_alu_op_o/id_rd_o/id_we_o/id_illegal_o  decoded control
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RA_W     = 5,
  parameter bit          RF_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  input  logic [31:0]     if_instr_i,
  output logic            if_ready_o,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_rs1_val_o,
  output logic [XLEN-1:0] id_rs2_val_o,
  output logic [3:0]      id_alu_op_o,
  output logic [RA_W-1:0] id_rd_o,
  output logic            id_we_o,
  output logic            id_illegal_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d;
  logic [XLEN-1:0] rs2_val_q, rs2_val_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic            we_q, we_d;
  logic            illegal_q, illegal_d;
  // Source indices kept so held operands can track later write-backs
  logic [RA_W-1:0] rs1_idx_q, rs1_idx_d;
  logic [RA_W-1:0] rs2_idx_q, rs2_idx_d;
  logic            is_imm_q, is_imm_d;

  logic [RA_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rf_rs1, rf_rs2, rs1_byp, rs2_byp, imm;
  logic            accept;
  dec_t            dec;

  assign rd_idx  = if_instr_i[7 +: RA_W];
  assign rs1_idx = if_instr_i[15 +: RA_W];
  assign rs2_idx = if_instr_i[20 +: RA_W];
  assign imm     = {{(XLEN-12){if_instr_i[31]}}, if_instr_i[31:20]};
  assign dec     = decode(if_instr_i[6:0], if_instr_i[14:12], if_instr_i[31:25]);

  id_stage_regfile #(
    .XLEN     (XLEN),
    .RA_W     (RA_W),
    .RF_RESET (RF_RESET)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_we_i),
    .waddr_i   (wb_rd_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (rs1_idx),
    .rdata_a_o (rf_rs1),
    .raddr_b_i (rs2_idx),
    .rdata_b_o (rf_rs2)
  );

  // Same-cycle bypass: the write landing at this edge is what the operand must see
  assign rs1_byp = (wb_we_i && wb_rd_i == rs1_idx && rs1_idx != '0) ? wb_data_i : rf_rs1;
  assign rs2_byp = (wb_we_i && wb_rd_i == rs2_idx && rs2_idx != '0) ? wb_data_i : rf_rs2;

  assign if_ready_o = ~valid_q | id_ready_i;
  assign accept     = if_valid_i & if_ready_o;

  always_comb begin
    valid_d   = valid_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    alu_op_d  = alu_op_q;
    rd_d      = rd_q;
    we_d      = we_q;
    illegal_d = illegal_q;
    rs1_idx_d = rs1_idx_q;
    rs2_idx_d = rs2_idx_q;
    is_imm_d  = is_imm_q;
    if (flush_i) begin
      // Incoming instruction is consumed and dropped
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      rs1_val_d = rs1_byp;
      rs2_val_d = dec.is_imm ? imm : rs2_byp;
      alu_op_d  = dec.alu_op;
      rd_d      = rd_idx;
      we_d      = ~dec.illegal && rd_idx != '0;
      illegal_d = dec.illegal;
      rs1_idx_d = rs1_idx;
      rs2_idx_d = rs2_idx;
      is_imm_d  = dec.is_imm;
    end else if (valid_q && id_ready_i) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Stalled: keep held operands coherent with the register file
      if (wb_we_i && wb_rd_i == rs1_idx_q && rs1_idx_q != '0) begin
        rs1_val_d = wb_data_i;
      end
      if (!is_imm_q && wb_we_i && wb_rd_i == rs2_idx_q && rs2_idx_q != '0) begin
        rs2_val_d = wb_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      alu_op_q  <= ALU_ADD;
      rd_q      <= '0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      is_imm_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      alu_op_q  <= alu_op_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
      rs1_idx_q <= rs1_idx_d;
      rs2_idx_q <= rs2_idx_d;
      is_imm_q  <= is_imm_d;
    end
  end

  assign id_valid_o   = valid_q;
  assign id_rs1_val_o = rs1_val_q;
  assign id_rs2_val_o = rs2_val_q;
  assign id_alu_op_o  = alu_op_q;
  assign id_rd_o      = rd_q;
  assign id_we_o      = we_q;
  assign id_illegal_o = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rd;
  logic        id_we;
  logic        id_illegal;

  always #5 clk = ~clk;

  id_stage #(
    .XLEN     (32),
    .RA_W     (5),
    .RF_RESET (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid_i   (if_valid),
    .if_instr_i   (if_instr),
    .if_ready_o   (if_ready),
    .flush_i      (flush),
    .wb_we_i      (wb_we),
    .wb_rd_i      (wb_rd),
    .wb_data_i    (wb_data),
    .id_valid_o   (id_valid),
    .id_ready_i   (id_ready),
    .id_rs1_val_o (id_rs1_val),
    .id_rs2_val_o (id_rs2_val),
    .id_alu_op_o  (id_alu_op),
    .id_rd_o      (id_rd),
    .id_we_o      (id_we),
    .id_illegal_o (id_illegal)
  );

  // Expected decode of an accepted instruction; operand values are taken from
  // the architectural register model when the instruction is presented.
  typedef struct {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  op;
    logic        we;
    logic        ill;
    logic        use_imm;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] rf[32];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          rst_seen = 1'b0;

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    e.rd      = ins[11:7];
    e.rs1     = ins[19:15];
    e.rs2     = ins[24:20];
    e.imm     = {{20{ins[31]}}, ins[31:20]};
    e.ill     = 1'b0;
    e.use_imm = 1'b0;
    e.op      = 4'd0;
    case ({ins[31:25], ins[14:12], ins[6:0]})
      {7'h00, 3'b000, 7'b0110011}: e.op = 4'd0;
      {7'h20, 3'b000, 7'b0110011}: e.op = 4'd1;
      {7'h00, 3'b111, 7'b0110011}: e.op = 4'd2;
      {7'h00, 3'b110, 7'b0110011}: e.op = 4'd3;
      {7'h00, 3'b100, 7'b0110011}: e.op = 4'd4;
      default: begin
        if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'b000) begin
          e.op      = 4'd5;
          e.use_imm = 1'b1;
        end else begin
          e.ill = 1'b1;
        end
      end
    endcase
    e.we = !e.ill && e.rd != 5'd0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Reference model: tracks what the next edge does to the architectural state.
  always @(posedge clk) begin
    bit pres;
    pres = sb_q.size() != 0;
    if (rst) begin
      sb_q.delete();
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      rst_seen = 1'b1;
    end else begin
      if (flush) begin
        sb_q.delete();
      end else if (if_valid && (!pres || id_ready)) begin
        sb_q.push_back(model(if_instr));
      end
      if (wb_we && wb_rd != 5'd0) rf[wb_rd] = wb_data;
    end
  end

  // Monitor: compares presented outputs against the scoreboard head.
  always @(negedge clk) begin
    bit   pres;
    exp_t e;
    pres = sb_q.size() != 0;
    if (rst_seen) begin
      rst_seen = 1'b0;
      check("rst_rs1", id_rs1_val, 32'd0);
      check("rst_rs2", id_rs2_val, 32'd0);
      check("rst_op", 32'(id_alu_op), 32'd0);
      check("rst_rd", 32'(id_rd), 32'd0);
      check("rst_we", 32'(id_we), 32'd0);
      check("rst_ill", 32'(id_illegal), 32'd0);
    end
    check("id_valid", 32'(id_valid), 32'(pres));
    check("if_ready", 32'(if_ready), 32'(!pres || id_ready));
    if (pres && id_valid) begin
      e = sb_q[0];
      check("alu_op", 32'(id_alu_op), 32'(e.op));
      check("rd", 32'(id_rd), 32'(e.rd));
      check("we", 32'(id_we), 32'(e.we));
      check("illegal", 32'(id_illegal), 32'(e.ill));
      if (!e.ill) begin
        check("rs1_val", id_rs1_val, rf[e.rs1]);
        check("rs2_val", id_rs2_val, e.use_imm ? e.imm : rf[e.rs2]);
      end
      if (id_ready) void'(sb_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic we,
                      input logic [4:0] rd, input logic [31:0] d, input logic rdy);
    if_valid = v;
    if_instr = ins;
    flush    = fl;
    wb_we    = we;
    wb_rd    = rd;
    wb_data  = d;
    id_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] ins;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 6))
      0: ins = {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
      1: ins = {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
      2: ins = {7'h00, rs2, rs1, 3'b111, rd, 7'b0110011};
      3: ins = {7'h00, rs2, rs1, 3'b110, rd, 7'b0110011};
      4: ins = {7'h00, rs2, rs1, 3'b100, rd, 7'b0110011};
      5: ins = {12'($urandom()), rs1, 3'b000, rd, 7'b0010011};
      default: ins = $urandom();
    endcase
    return ins;
  endfunction

  initial begin
    rst = 1'b1;
    step(0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
    step(0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
    rst = 1'b0;
    step(0, 32'd0, 0, 1, 5'd1, 32'd5, 1);
    step(0, 32'd0, 0, 1, 5'd2, 32'd3, 1);
    step(1, 32'h002081B3, 0, 0, 5'd0, 32'd0, 1);          // add x3,x1,x2
    step(1, 32'h40208233, 0, 1, 5'd1, 32'hDEADBEEF, 1);   // sub with same-cycle bypass
    step(1, 32'hFFF08293, 0, 0, 5'd0, 32'd0, 1);          // addi x5,x1,-1
    step(1, 32'h00108013, 0, 0, 5'd0, 32'd0, 1);          // addi x0,x1,1
    step(1, 32'h002081B3, 0, 0, 5'd0, 32'd0, 1);          // add, then stall
    step(1, 32'h0020C1B3, 0, 0, 5'd0, 32'd0, 0);
    step(1, 32'h0020C1B3, 0, 1, 5'd1, 32'd7, 0);          // refresh held rs1
    step(1, 32'h0020C1B3, 0, 0, 5'd0, 32'd0, 0);
    step(1, 32'h0020F1B3, 0, 0, 5'd0, 32'd0, 1);          // release; accept and
    step(1, 32'h0020E1B3, 1, 0, 5'd0, 32'd0, 0);          // flush held and incoming
    step(0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
    step(1, 32'h00000073, 0, 0, 5'd0, 32'd0, 1);          // illegal
    step(1, 32'h0020C1B3, 0, 0, 5'd0, 32'd0, 1);          // xor
    step(1, 32'h002081B3, 0, 0, 5'd0, 32'd0, 0);          // stall xor
    rst = 1'b1;
    step(1, 32'h002081B3, 1, 1, 5'd1, 32'd9, 0);          // reset beats accept/wb/flush
    rst = 1'b0;
    step(1, 32'h002081B3, 0, 0, 5'd0, 32'd0, 1);          // x1 now reads 0
    step(0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom(),
           $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    step(0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
    step(0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
